beta_mailbox: RTL and testbench

Parametrised multi-channel mailbox connecting the physics beta (producer) to the laser beta (consumer) through memory-mapped registers. It generalises the fixed shared read/write windows into NUM_CH independent FIFOs of configurable depth and width, each with status, sticky error flags and an optional consumer interrupt. Both CPU buses reach it through their existing address decoders: the producer asserts p_sel, the consumer asserts c_sel.

---
 rtl/mailbox_pkg.sv | 25 ++
 rtl/mailbox_fifo.sv | 64 ++++++
 rtl/beta_mailbox.sv | 157 +++++++++++++++
 tb/tb_beta_mailbox.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// Shared register map, STATUS bit positions and status word layout for beta_mailbox.
package mailbox_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    localparam int unsigned ST_COUNT_LSB = 0;
    localparam int unsigned ST_COUNT_W   = 16;
    localparam int unsigned ST_EMPTY     = 16;
    localparam int unsigned ST_FULL      = 17;
    localparam int unsigned ST_OVF       = 18;
    localparam int unsigned ST_UNF       = 19;

    typedef struct packed {
        logic [11:0] rsvd;
        logic        unf;
        logic        ovf;
        logic        full;
        logic        empty;
        logic [15:0] count;
    } status_t;

endpackage

// File: rtl/mailbox_fifo.sv
// Single mailbox channel: FIFO storage, occupancy count and sticky overflow/underflow flags.
module mailbox_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     unf
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign pop_ok  = pop & ~empty & ~clr;
    assign push_ok = push & (~full | pop) & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop_ok)  rp <= rp + AW'(1);
            count <= count + CNTW'(push_ok) - CNTW'(pop_ok);
            if (push && full && !pop) ovf <= 1'b1;
            if (pop && empty)         unf <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= wdata;
    end

    assign head = empty ? '0 : mem[rp];

endmodule

// File: rtl/beta_mailbox.sv
// Multi-channel producer/consumer mailbox: address decode, THRESH registers, read muxing and irq.
// Optional consumer interrupt built when MAILBOX_IRQ_EN is defined; otherwise irq_c is tied low.
module beta_mailbox
    import mailbox_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_din,
    input  logic        p_we,
    input  logic        p_sel,
    output logic [31:0] p_dout,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_din,
    input  logic        c_we,
    input  logic        c_sel,
    output logic [31:0] c_dout,
    output logic        irq_c
);

    localparam int unsigned CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [1:0]                         rst_sync;
    logic                               rst_n;
    logic [CW-1:0]                      p_ch;
    logic [CW-1:0]                      c_ch;
    logic [1:0]                         p_off;
    logic [1:0]                         c_off;
    logic                               p_wr;
    logic                               c_wr;
    logic [NUM_CH-1:0]                  push;
    logic [NUM_CH-1:0]                  pop;
    logic [NUM_CH-1:0]                  clr;
    logic [NUM_CH-1:0]                  ovf;
    logic [NUM_CH-1:0]                  unf;
    logic [NUM_CH-1:0][CNTW-1:0]        cnt;
    logic [NUM_CH-1:0][CNTW-1:0]        thr;
    logic [NUM_CH-1:0][DATA_W-1:0]      head;
    status_t [NUM_CH-1:0]               st;
    logic [31:0]                        p_rd;
    logic [31:0]                        c_rd;
    logic                               unused_ok;

    // Assert asynchronously, release through two flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign p_ch      = p_addr[4+CW-1:4];
    assign c_ch      = c_addr[4+CW-1:4];
    assign p_off     = p_addr[3:2];
    assign c_off     = c_addr[3:2];
    assign p_wr      = p_sel & p_we;
    assign c_wr      = c_sel & c_we;
    assign unused_ok = ^{p_addr, c_addr, p_din, c_din};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CW-1:0] IDX = CW'(i);

        assign push[i] = p_wr && (p_ch == IDX) && (p_off == REG_DATA);
        assign clr[i]  = p_wr && (p_ch == IDX) && (p_off == REG_CTRL);
        assign pop[i]  = c_wr && (c_ch == IDX) && (c_off == REG_CTRL);

        mailbox_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr[i]),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (p_din[DATA_W-1:0]),
            .head  (head[i]),
            .count (cnt[i]),
            .ovf   (ovf[i]),
            .unf   (unf[i])
        );

        assign st[i] = '{rsvd:  '0,
                         unf:   unf[i],
                         ovf:   ovf[i],
                         full:  (cnt[i] == CNTW'(DEPTH)),
                         empty: (cnt[i] == '0),
                         count: 16'(cnt[i])};

        // Producer wins a same-cycle THRESH collision
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                thr[i] <= CNTW'(1);
            end else if (p_wr && (p_ch == IDX) && (p_off == REG_THRESH)) begin
                thr[i] <= p_din[CNTW-1:0];
            end else if (c_wr && (c_ch == IDX) && (c_off == REG_THRESH)) begin
                thr[i] <= c_din[CNTW-1:0];
            end
        end
    end

    function automatic logic [31:0] reg_word(input status_t s, input logic [DATA_W-1:0] h,
                                             input logic [CNTW-1:0] t, input logic [1:0] off);
        case (off)
            REG_DATA:   return 32'(h);
            REG_STATUS: return 32'(s);
            REG_THRESH: return 32'(t);
            default:    return '0;
        endcase
    endfunction

    // Out-of-range channel indices match no entry and read as zero
    always_comb begin
        p_rd = '0;
        c_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (p_ch == CW'(i)) p_rd = reg_word(st[i], head[i], thr[i], p_off);
            if (c_ch == CW'(i)) c_rd = reg_word(st[i], head[i], thr[i], c_off);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_dout <= '0;
            c_dout <= '0;
        end else begin
            p_dout <= p_sel ? p_rd : '0;
            c_dout <= c_sel ? c_rd : '0;
        end
    end

`ifdef MAILBOX_IRQ_EN
    logic irq_hit;
    logic irq_q;

    always_comb begin
        irq_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            irq_hit = irq_hit | ((thr[i] != '0) && (cnt[i] >= thr[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_hit;
    end

    assign irq_c = irq_q;
`else
    assign irq_c = 1'b0;
`endif

endmodule

// File: tb/tb_beta_mailbox.sv
// Self-checking bench for beta_mailbox: directed scenarios plus randomized traffic against a queue model.
module tb_beta_mailbox;
    import mailbox_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNTW   = 5;
`ifdef MAILBOX_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] p_addr, p_din, p_dout, c_addr, c_din, c_dout;
    logic        p_we, p_sel, c_we, c_sel, irq_c;

    always #5 clk = ~clk;

    beta_mailbox #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .p_addr (p_addr),
        .p_din  (p_din),
        .p_we   (p_we),
        .p_sel  (p_sel),
        .p_dout (p_dout),
        .c_addr (c_addr),
        .c_din  (c_din),
        .c_we   (c_we),
        .c_sel  (c_sel),
        .c_dout (c_dout),
        .irq_c  (irq_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per channel plus flags and thresholds
    logic [31:0]     mq [NUM_CH][$];
    logic            m_ovf [NUM_CH];
    logic            m_unf [NUM_CH];
    logic [CNTW-1:0] m_thr [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr(input int ch, input logic [1:0] off);
        return (32'(ch) << 4) | (32'(off) << 2);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            m_thr[i] = CNTW'(1);
        end
    endfunction

    function automatic logic [31:0] m_read(input int ch, input logic [1:0] off, output bit care);
        int n;
        n    = mq[ch].size();
        care = 1'b1;
        case (off)
            REG_DATA: begin
                if (n == 0) begin
                    care = 1'b0;
                    return 32'h0;
                end
                return mq[ch][0];
            end
            REG_STATUS: return {12'b0, m_unf[ch], m_ovf[ch], (n == DEPTH), (n == 0), 16'(n)};
            REG_THRESH: return 32'(m_thr[ch]);
            default: begin
                care = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    function automatic logic m_irq();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_thr[i] != 0 && mq[i].size() >= int'(m_thr[i])) r = 1'b1;
        return r;
    endfunction

    function automatic void m_apply();
        int         pch, cch;
        logic [1:0] po, co;
        bit         pw, cw, clr, do_pop, do_push;
        pch = int'(p_addr[5:4]);
        cch = int'(c_addr[5:4]);
        po  = p_addr[3:2];
        co  = c_addr[3:2];
        pw  = p_sel && p_we;
        cw  = c_sel && c_we;
        if (cw && co == REG_THRESH) m_thr[cch] = c_din[CNTW-1:0];
        if (pw && po == REG_THRESH) m_thr[pch] = p_din[CNTW-1:0];
        clr     = pw && po == REG_CTRL;
        do_push = pw && po == REG_DATA;
        do_pop  = cw && co == REG_CTRL && !(clr && pch == cch);
        if (clr) begin
            mq[pch].delete();
            m_ovf[pch] = 1'b0;
            m_unf[pch] = 1'b0;
        end
        if (do_pop) begin
            if (mq[cch].size() == 0) m_unf[cch] = 1'b1;
            else void'(mq[cch].pop_front());
        end
        if (do_push) begin
            if (mq[pch].size() < DEPTH) mq[pch].push_back(p_din);
            else m_ovf[pch] = 1'b1;
        end
    endfunction

    task automatic p_op(input bit we, input int ch, input logic [1:0] off, input logic [31:0] d);
        p_sel = 1'b1; p_we = we; p_addr = addr(ch, off); p_din = d;
    endtask

    task automatic c_op(input bit we, input int ch, input logic [1:0] off, input logic [31:0] d);
        c_sel = 1'b1; c_we = we; c_addr = addr(ch, off); c_din = d;
    endtask

    task automatic p_idle();
        p_sel = 1'b0; p_we = 1'b0;
    endtask

    task automatic c_idle();
        c_sel = 1'b0; c_we = 1'b0;
    endtask

    // One clock: predict reads/irq from the pre-edge model state, then advance the model
    task automatic tick(input string tag);
        bit          pc, cc;
        logic [31:0] pe, ce;
        logic        ie;
        pe = m_read(int'(p_addr[5:4]), p_addr[3:2], pc);
        ce = m_read(int'(c_addr[5:4]), c_addr[3:2], cc);
        pc = pc & p_sel & !p_we;
        cc = cc & c_sel & !c_we;
        ie = m_irq() & IRQ_ON;
        @(posedge clk);
        #1;
        m_apply();
        if (pc) check({tag, "/p_dout"}, p_dout, pe);
        if (cc) check({tag, "/c_dout"}, c_dout, ce);
        check({tag, "/irq"}, 32'(irq_c), 32'(ie));
    endtask

    function automatic logic [1:0] rnd_off(input int w_data, input int w_stat, input int w_ctrl);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < w_data)                   return REG_DATA;
        if (r < w_data + w_stat)          return REG_STATUS;
        if (r < w_data + w_stat + w_ctrl) return REG_CTRL;
        return REG_THRESH;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        p_addr = '0; p_din = '0; c_addr = '0; c_din = '0;
        p_idle();
        c_idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_p_dout", p_dout, 32'h0);
        check("rst_c_dout", c_dout, 32'h0);
        check("rst_irq", 32'(irq_c), 32'h0);
        reset = 1'b1;
        repeat (3) tick("sync");

        // Post-reset STATUS and THRESH of channel 0
        p_op(0, 0, REG_STATUS, 0); tick("t1_status");
        check("t1_status_k", p_dout, 32'h0001_0000);
        p_op(0, 0, REG_THRESH, 0); tick("t1_thresh");
        check("t1_thresh_k", p_dout, 32'h0000_0001);

        // Overfill channel 1, then drain while reading the head
        for (int k = 0; k < 17; k++) begin
            p_op(1, 1, REG_DATA, 32'h11 + 32'(k));
            tick("t2_push");
        end
        p_op(0, 1, REG_STATUS, 0); tick("t2_status");
        check("t2_status_k", p_dout, 32'h0006_0010);
        p_op(0, 1, REG_DATA, 0); tick("t2_head");
        check("t2_head_k", p_dout, 32'h11);
        for (int k = 0; k < 16; k++) begin
            p_op(0, 1, REG_DATA, 0);
            c_op(1, 1, REG_CTRL, 0);
            tick("t2_pop");
            check("t2_pop_k", p_dout, 32'h11 + 32'(k));
        end
        c_idle();

        // Push and pop together on an empty channel
        p_op(1, 2, REG_DATA, 32'hAB); c_op(1, 2, REG_CTRL, 0); tick("t3_pp");
        c_idle();
        p_op(0, 2, REG_STATUS, 0); tick("t3_status");
        check("t3_status_k", p_dout, 32'h0008_0001);
        p_op(0, 2, REG_DATA, 0); tick("t3_data");
        check("t3_data_k", p_dout, 32'hAB);

        // Clear racing a pop
        for (int k = 0; k < 4; k++) begin
            p_op(1, 3, REG_DATA, 32'h30 + 32'(k));
            tick("t4_fill");
        end
        p_op(1, 3, REG_CTRL, 0); c_op(1, 3, REG_CTRL, 0); tick("t4_clr");
        c_idle();
        p_op(0, 3, REG_STATUS, 0); tick("t4_status");
        check("t4_status_k", p_dout, 32'h0001_0000);

        // Threshold interrupt on channel 0
        p_op(1, 2, REG_CTRL, 0); tick("t5_clr2");
        p_idle();
        c_op(1, 0, REG_THRESH, 3); tick("t5_thr");
        c_idle();
        for (int k = 0; k < 3; k++) begin
            p_op(1, 0, REG_DATA, 32'h50 + 32'(k));
            tick("t5_push");
        end
        p_idle(); tick("t5_rise");
        check("t5_rise_k", 32'(irq_c), 32'(IRQ_ON));
        c_op(1, 0, REG_CTRL, 0); tick("t5_pop");
        c_idle(); tick("t5_fall");
        check("t5_fall_k", 32'(irq_c), 32'h0);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) begin
            p_op(1, 1, REG_DATA, 32'h60 + 32'(k));
            tick("t6_push");
        end
        p_op(0, 1, REG_STATUS, 0); c_op(0, 0, REG_THRESH, 0); tick("t6_pre");
        p_idle(); c_idle();
        reset = 1'b0;
        #1;
        check("t6_rst_p_dout", p_dout, 32'h0);
        check("t6_rst_c_dout", c_dout, 32'h0);
        check("t6_rst_irq", 32'(irq_c), 32'h0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick("t6_sync");
        p_op(0, 1, REG_STATUS, 0); c_op(0, 0, REG_THRESH, 0); tick("t6_post");
        check("t6_status_k", p_dout, 32'h0001_0000);
        check("t6_thresh_k", c_dout, 32'h0000_0001);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int it = 0; it < 800; it++) begin
            bit         fill;
            logic [1:0] off;
            int         ch;
            fill = ((it / 100) % 2) == 0;
            if ($urandom_range(0, 9) < 8) begin
                ch  = int'($urandom_range(0, NUM_CH - 1));
                off = fill ? rnd_off(65, 15, 3) : rnd_off(25, 30, 5);
                p_op(1'($urandom_range(0, 9) < 7), ch, off,
                     (off == REG_THRESH && $urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 18)) : $urandom());
                p_addr = p_addr | ($urandom() & 32'hFFFF_FFC3);
            end else begin
                p_idle();
            end
            if ($urandom_range(0, 9) < 8) begin
                ch  = int'($urandom_range(0, NUM_CH - 1));
                off = fill ? rnd_off(30, 30, 15) : rnd_off(20, 20, 50);
                c_op(1'($urandom_range(0, 1)), ch, off,
                     (off == REG_THRESH) ? 32'($urandom_range(0, 18)) : $urandom());
                c_addr = c_addr | ($urandom() & 32'hFFFF_FFC3);
            end else begin
                c_idle();
            end
            tick("rnd");
        end

        c_idle();
        for (int i = 0; i < NUM_CH; i++) begin
            p_op(0, i, REG_STATUS, 0);
            tick("final_status");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
